// File: rtl/brisc_pkg.sv
// Shared types and sizing helpers for the operand-forwarding scoreboard.
package brisc_pkg;

  localparam int REG_BITS = 5;
  localparam int NUM_REGS = 1 << REG_BITS;

  // Producer class of an issuing instruction; selects its result latency.
  typedef enum logic [1:0] {
    FWD_ALU  = 2'd0,
    FWD_LOAD = 2'd1,
    FWD_MUL  = 2'd2
  } fwd_kind_e;

  // Where an operand is finally taken from: register file or a bypass stage.
  typedef enum logic [0:0] {
    FWD_SRC_RF    = 1'b0,
    FWD_SRC_STAGE = 1'b1
  } fwd_src_e;

  // Width of a forwarding select able to name "none" plus n stages.
  function automatic int sel_bits_f(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of a countdown timer able to hold the longest latency.
  function automatic int timer_bits_f(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Cycles from issue until the producer's result is forwardable.
  function automatic int kind_lat_f(input fwd_kind_e k, input int load_lat,
                                    input int mul_lat);
    case (k)
      FWD_LOAD: return load_lat;
      FWD_MUL:  return mul_lat;
      default:  return 0;
    endcase
  endfunction

  localparam int FWD_NUM_STAGES_DEF = 2;
  localparam int SEL_BITS           = sel_bits_f(FWD_NUM_STAGES_DEF);
  localparam int FWD_SEL_NONE       = 0;

endpackage

// File: rtl/fwd_scoreboard_reg_timer.sv
// Per-register countdown: loadable, saturates at zero, reports transitions
// between idle and busy so the owner can keep a running busy count.
module reg_timer #(
  parameter int TW = 3
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  output logic [TW-1:0] o_value,
  output logic          o_nonzero,
  output logic          o_set,
  output logic          o_clear
);

  logic [TW-1:0] r_value;
  logic [TW-1:0] w_next;

  // Next value: a load wins over the decrement; zero holds.
  always_comb begin
    w_next = r_value;
    if (i_load) begin
      w_next = i_load_val;
    end else if (r_value != '0) begin
      w_next = r_value - 1'b1;
    end
  end

  // Timer state register.
  // NOTE: state uses <= so every flop samples pre-edge values; each timer is
  // its own flop bank, so reset clears all in-flight tracking at once.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_value <= '0;
    end else begin
      r_value <= w_next;
    end
  end

  assign o_value   = r_value;
  assign o_nonzero = (r_value != '0);
  assign o_set     = (r_value == '0) && (w_next != '0);
  assign o_clear   = (r_value != '0) && (w_next == '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// Issue-stage hazard scoreboard: tracks per-register result latency,
// stalls on RAW/WAW hazards and picks the youngest matching bypass stage.
module fwd_scoreboard
  import brisc_pkg::*;
#(
  parameter  int NUM_SRC    = 2,
  parameter  int NUM_STAGES = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int MUL_LAT    = 5,
  localparam int SEL_W      = sel_bits_f(NUM_STAGES),
  localparam int CNT_W      = REG_BITS + 1
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic                                 issue_valid_in,
  input  logic [REG_BITS-1:0]                  issue_rd_in,
  input  logic                                 issue_reg_write_in,
  input  fwd_kind_e                            issue_kind_in,
  input  logic [NUM_SRC-1:0][REG_BITS-1:0]     rs_in,
  input  logic [NUM_SRC-1:0]                   rs_used_in,
  input  logic                                 flush_in,
  input  logic [NUM_STAGES-1:0][REG_BITS-1:0]  stage_rd_in,
  input  logic [NUM_STAGES-1:0]                stage_wr_in,
  output logic [NUM_SRC-1:0][SEL_W-1:0]        fwd_sel_out,
  output logic                                 stall_out,
  output logic [CNT_W-1:0]                     pending_cnt_out
);

  localparam int TW = timer_bits_f(LOAD_LAT, MUL_LAT);

  logic [TW-1:0]       w_timer [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clear;
  logic [TW-1:0]       w_issue_lat;
  logic                w_raw;
  logic                w_waw;
  logic                w_accept;
  logic                w_load_en;
  logic [CNT_W-1:0]    w_inc;
  logic [CNT_W-1:0]    w_dec;
  logic [CNT_W-1:0]    r_pending;

  // x0 is hardwired: never busy, never counted.
  assign w_timer[0] = '0;
  assign w_busy[0]  = 1'b0;
  assign w_set[0]   = 1'b0;
  assign w_clear[0] = 1'b0;

  assign w_issue_lat = TW'(kind_lat_f(issue_kind_in, LOAD_LAT, MUL_LAT));

  // RAW hazard: a read operand whose producer has not reached a bypass stage.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_used_in[i] && (rs_in[i] != '0) && w_busy[rs_in[i]]) begin
        w_raw = 1'b1;
      end
    end
  end

  // WAW: an older, slower producer of rd would otherwise retire after us.
  // The self-dependence case reads the pre-issue timer, so it never stalls
  // on its own load.
  assign w_waw = issue_valid_in && issue_reg_write_in && (issue_rd_in != '0) &&
                 (w_timer[issue_rd_in] > w_issue_lat);

  // Stall depends only on timers and issue fields, never on stage inputs.
  assign stall_out = w_raw | w_waw;
  assign w_accept  = issue_valid_in & ~stall_out & ~flush_in;
  assign w_load_en = w_accept & issue_reg_write_in & (issue_rd_in != '0);

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_timer
    reg_timer #(
      .TW(TW)
    ) u_timer (
      .clk_in     (clk_in),
      .reset_in   (reset_in),
      .i_load     (w_load_en && (issue_rd_in == REG_BITS'(g))),
      .i_load_val (w_issue_lat),
      .o_value    (w_timer[g]),
      .o_nonzero  (w_busy[g]),
      .o_set      (w_set[g]),
      .o_clear    (w_clear[g])
    );
  end

  // Tally idle-to-busy and busy-to-idle transitions happening at this edge.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc = w_inc + CNT_W'(w_set[r]);
      w_dec = w_dec + CNT_W'(w_clear[r]);
    end
  end

  // Running count of busy registers, updated with the timers.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_pending <= '0;
    end else begin
      r_pending <= r_pending + w_inc - w_dec;
    end
  end

  assign pending_cnt_out = r_pending;

  // Bypass select: youngest (lowest-index) stage writing the source register.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel_out[i] = SEL_W'(FWD_SEL_NONE);
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (stage_wr_in[k] && (stage_rd_in[k] == rs_in[i]) && (rs_in[i] != '0)) begin
          fwd_sel_out[i] = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed vector table, a mid-countdown reset
// sequence, then random traffic against a latency-table reference model.
module tb_fwd_scoreboard;
  import brisc_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_in;
  logic                 valid;
  logic [4:0]           rd;
  logic                 wr;
  fwd_kind_e            kind;
  logic [1:0][4:0]      rs;
  logic [1:0]           used;
  logic                 flush;
  logic [1:0][4:0]      srd;
  logic [1:0]           swr;
  logic [1:0][1:0]      fwd_sel;
  logic                 stall_out;
  logic [5:0]           pend;

  int n_checks = 0;
  int n_err    = 0;
  int m_timer [32];

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .NUM_SRC(2), .NUM_STAGES(2), .LOAD_LAT(1), .MUL_LAT(5)
  ) dut (
    .clk_in             (clk),
    .reset_in           (reset_in),
    .issue_valid_in     (valid),
    .issue_rd_in        (rd),
    .issue_reg_write_in (wr),
    .issue_kind_in      (kind),
    .rs_in              (rs),
    .rs_used_in         (used),
    .flush_in           (flush),
    .stage_rd_in        (srd),
    .stage_wr_in        (swr),
    .fwd_sel_out        (fwd_sel),
    .stall_out          (stall_out),
    .pending_cnt_out    (pend)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int lat_of(input fwd_kind_e k);
    case (k)
      FWD_LOAD: return 1;
      FWD_MUL:  return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic bit model_stall();
    bit s = 1'b0;
    for (int i = 0; i < 2; i++)
      if (used[i] && rs[i] != 0 && m_timer[rs[i]] > 0) s = 1'b1;
    if (valid && wr && rd != 0 && m_timer[rd] > lat_of(kind)) s = 1'b1;
    return s;
  endfunction

  function automatic int model_sel(input int i);
    if (rs[i] == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (swr[k] && srd[k] == rs[i]) return k + 1;
    return 0;
  endfunction

  function automatic int model_pending();
    int c = 0;
    for (int r = 1; r < 32; r++) if (m_timer[r] != 0) c++;
    return c;
  endfunction

  task automatic model_edge(input bit acc);
    for (int r = 1; r < 32; r++) if (m_timer[r] > 0) m_timer[r]--;
    if (acc && wr && rd != 0) m_timer[rd] = lat_of(kind);
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) m_timer[r] = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input bit w, input int d, input fwd_kind_e k,
                       input int s0, input int s1, input bit [1:0] u, input bit f,
                       input int r0, input int r1, input bit [1:0] sw);
    valid = v; wr = w; rd = 5'(d); kind = k;
    rs[0] = 5'(s0); rs[1] = 5'(s1); used = u; flush = f;
    srd[0] = 5'(r0); srd[1] = 5'(r1); swr = sw;
  endtask

  // Inputs already driven; compare at negedge, then advance model on the edge.
  task automatic run_cycle(input string name, input bit use_exp, input bit e_stall,
                           input int e_sel0, input int e_pend);
    bit ms;
    bit acc;
    @(negedge clk);
    ms = model_stall();
    check({name, " stall"}, 32'(stall_out), 32'(ms));
    for (int i = 0; i < 2; i++)
      check($sformatf("%s sel%0d", name, i), 32'(fwd_sel[i]), model_sel(i));
    check({name, " pending"}, 32'(pend), model_pending());
    if (use_exp) begin
      check({name, " tbl_stall"}, 32'(stall_out), 32'(e_stall));
      check({name, " tbl_sel0"}, 32'(fwd_sel[0]), e_sel0);
      check({name, " tbl_pending"}, 32'(pend), e_pend);
    end
    acc = valid && !ms && !flush;
    @(posedge clk);
    model_edge(acc);
    #1;
  endtask

  // Reset asserted away from the edge; outputs must clear immediately.
  task automatic pulse_reset(input string name);
    @(negedge clk);
    reset_in = 1'b1;
    #1;
    model_clear();
    check({name, " rst_stall"}, 32'(stall_out), 32'(model_stall()));
    check({name, " rst_pending"}, 32'(pend), 0);
    @(posedge clk);
    #1;
    reset_in = 1'b0;
  endtask

  typedef struct {
    bit        v, w;
    int        d;
    fwd_kind_e k;
    int        s0;
    bit [1:0]  u;
    bit        f;
    int        r0, r1;
    bit [1:0]  sw;
    bit        e_stall;
    int        e_sel0, e_pend;
    string     name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit v, input bit w, input int d, input fwd_kind_e k,
                     input int s0, input bit [1:0] u, input bit f, input int r0,
                     input int r1, input bit [1:0] sw, input bit es, input int esel,
                     input int ep, input string n);
    vec_t t;
    t.v = v; t.w = w; t.d = d; t.k = k; t.s0 = s0; t.u = u; t.f = f;
    t.r0 = r0; t.r1 = r1; t.sw = sw; t.e_stall = es; t.e_sel0 = esel;
    t.e_pend = ep; t.name = n;
    vecs.push_back(t);
  endtask

  initial begin
    model_clear();
    reset_in = 1'b1;
    drive(0, 0, 0, FWD_ALU, 0, 0, 2'b00, 0, 0, 0, 2'b00);

    // Vector table: v w rd kind rs0 used flush srd0 srd1 swr | stall sel0 pend
    add(1,1,5,FWD_ALU, 0,2'b00,0, 0,0,2'b00, 0,0,0, "alu_x5");
    add(1,0,0,FWD_ALU, 5,2'b01,0, 5,0,2'b01, 0,1,0, "use_x5_fwd");
    add(1,1,6,FWD_LOAD,0,2'b00,0, 0,0,2'b00, 0,0,0, "load_x6");
    add(1,0,0,FWD_ALU, 6,2'b01,0, 0,0,2'b00, 1,0,1, "use_x6_stall");
    add(1,0,0,FWD_ALU, 6,2'b01,0, 0,0,2'b00, 0,0,0, "use_x6_go");
    add(1,1,7,FWD_MUL, 0,2'b00,0, 0,0,2'b00, 0,0,0, "mul_x7");
    for (int c = 1; c <= 5; c++)
      add(1,0,0,FWD_ALU, 7,2'b01,0, 0,0,2'b00, 1,0,1, $sformatf("use_x7_stall%0d", c));
    add(1,0,0,FWD_ALU, 7,2'b01,0, 0,0,2'b00, 0,0,0, "use_x7_go");
    add(1,1,8,FWD_MUL, 0,2'b00,0, 0,0,2'b00, 0,0,0, "mul_x8");
    for (int c = 1; c <= 5; c++)
      add(1,1,8,FWD_ALU, 0,2'b00,0, 0,0,2'b00, 1,0,1, $sformatf("waw_x8_stall%0d", c));
    add(1,1,8,FWD_ALU, 0,2'b00,0, 0,0,2'b00, 0,0,0, "waw_x8_go");
    add(0,0,0,FWD_ALU, 0,2'b00,0, 0,0,2'b00, 0,0,0, "idle_after_alu");
    add(0,0,0,FWD_ALU, 8,2'b01,0, 8,8,2'b11, 0,1,0, "x8_both_stages");
    add(0,0,0,FWD_ALU, 8,2'b01,0, 3,8,2'b11, 0,2,0, "x8_older_stage");
    add(0,0,0,FWD_ALU, 8,2'b01,0, 8,8,2'b10, 0,2,0, "x8_young_invalid");
    add(0,0,0,FWD_ALU, 0,2'b01,0, 0,0,2'b11, 0,0,0, "x0_no_fwd");
    add(1,1,9,FWD_MUL, 0,2'b00,1, 0,0,2'b00, 0,0,0, "mul_x9_flush");
    add(1,0,0,FWD_ALU, 9,2'b01,0, 0,0,2'b00, 0,0,0, "x9_after_flush");
    add(1,1,10,FWD_MUL,10,2'b01,0, 0,0,2'b00, 0,0,0, "mul_x10_self");
    add(0,0,0,FWD_ALU, 0,2'b00,0, 0,0,2'b00, 0,0,1, "x10_pending");
    add(1,0,0,FWD_ALU, 10,2'b01,0, 0,0,2'b00, 1,0,1, "use_x10_stall");

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", 32'(stall_out), 0);
    check("reset pending", 32'(pend), 0);
    reset_in = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].v, vecs[n].w, vecs[n].d, vecs[n].k, vecs[n].s0, 0, vecs[n].u,
            vecs[n].f, vecs[n].r0, vecs[n].r1, vecs[n].sw);
      run_cycle(vecs[n].name, 1'b1, vecs[n].e_stall, vecs[n].e_sel0, vecs[n].e_pend);
    end

    // Reset mid-MUL countdown on x10: stall drops at once, tracking is gone.
    drive(1, 0, 0, FWD_ALU, 10, 0, 2'b01, 0, 0, 0, 2'b00);
    pulse_reset("mid_mul");
    run_cycle("after_reset", 1'b1, 1'b0, 0, 0);
    drive(1, 1, 11, FWD_LOAD, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    run_cycle("post_reset_load", 1'b1, 1'b0, 0, 0);
    drive(1, 0, 0, FWD_ALU, 0, 11, 2'b10, 0, 0, 0, 2'b00);
    run_cycle("post_reset_use", 1'b0, 1'b0, 0, 0);

    // Random traffic over a small register window to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset("rand_reset");
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), fwd_kind_e'($urandom_range(0, 2)),
            $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)));
      run_cycle($sformatf("rand%0d", c), 1'b0, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
